shift_add_multiplier: RTL and testbench
=======================================

Name: shift_add_multiplier

Overview:
- Sequential unsigned 8x8 shift-and-add multiplier.
- Sits directly around the hybrid_adder block:
  - drives its a/b operands each iteration;
  - consumes its sum/cout to form the next partial product.
- Produces a 16-bit product with a start/busy/done handshake.
- One adder pass per clock.

Parameters:
- WIDTH, 8, operand width. Only 8 is supported, to match hybrid_adder; 16-bit product.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  synchronous active-high reset
- start  input  1  request a multiply; sampled on the rising edge
- a  input  8  multiplicand, captured when start is accepted
- b  input  8  multiplier, captured when start is accepted
- product  output  16  result; valid and held from done until the next accepted start
- busy  output  1  high while state is RUN
- done  output  1  one-cycle pulse when product becomes valid

Behaviour:
- Clock and reset
  - Single clock domain: clk.
  - rst is synchronous, active-high, and takes priority over every other input.
  - Reset values: state=IDLE, product=0, busy=0, done=0, internal M/ACC/Q/count=0.
- States: IDLE, RUN, DONE (2-bit encoding).
- Start acceptance
  - start is accepted only in IDLE or DONE. In RUN it is ignored.
  - On accept: M<=a, Q<=b, ACC<=0, cout_r<=0, count<=0, state<=RUN.
  - M and Q are latched, so a/b may change after the accepting edge.
- RUN iteration (one per clock)
  - Adder operands: a=ACC, b=(Q[0] ? M : 8'h00), cin=0. This is the hybrid_adder call.
  - Register update: {ACC,Q} <= {cout,sum,Q[7:1]}, i.e. a 17-bit {cout,sum,Q} shifted right by 1 and truncated to 16 bits.
  - count <= count+1.
  - When count==7 at the edge (8th iteration): state<=DONE, product<={next ACC, next Q}.
- DONE
  - done=1 for exactly this one cycle; busy=0; then state<=IDLE unless start is accepted.
  - Back-to-back operation: start high during DONE is accepted, so the next state is RUN and done deasserts.
- Latency
  - Start accepted at edge E.
  - busy=1 from E through E+8.
  - done=1 in the cycle after edge E+8.
  - Total: 8 RUN cycles plus 1 DONE cycle.
- Output holding
  - product changes only on entry to DONE or on reset.
  - product holds its value across IDLE and across a following RUN.
- Arithmetic
  - Unsigned only. The product always fits 16 bits; ACC carry is never lost because cout shifts into ACC[7].
- Reset mid-operation: the next cycle is IDLE with all outputs 0. The partial result is discarded.
- Combined conditions
  - start and rst high together: reset wins.
  - start held high continuously: a new multiply is re-issued every 9 cycles (once per DONE).

Optional Feature:
- Macro: EARLY_TERM_EN
- Defined: early termination.
  - At the start of each RUN cycle, if the unconsumed multiplier bits (Q[7-count:0]) are all zero, skip the add.
  - Instead: state<=DONE, product<=({ACC,Q} >> (8-count)).
  - Result: b=0 finishes after 1 RUN cycle; b=1 finishes after 2 RUN cycles.
  - busy spans only the cycles actually used.
  - product value is identical to the non-early result.
- Not defined: fixed 8-iteration latency as specified above. No early-exit logic is synthesised.

Test Plan:
- rst=1 for 2 cycles with start=1 -> product=16'h0000, busy=0, done=0 throughout; no RUN entry.
- start with a=13, b=11 -> busy for 8 cycles, done pulse 1 cycle, product=16'h008F (143).
- start with a=255, b=255 -> product=16'hFE01. Exercises cout into ACC on every iteration.
- start a=200, b=3; pulse start with a=1, b=1 at cycle 4 of RUN -> ignored; product=16'h0258 (600). Then start held during DONE with a=7, b=9 -> immediate RUN, next product=16'h003F.
- start a=100, b=100; rst=1 at cycle 5 of RUN -> next cycle IDLE, busy=0, product=0, no done pulse.
- With EARLY_TERM_EN:
  - a=77, b=0 -> done 2 cycles after accept, product=0.
  - a=77, b=1 -> done after 2 RUN cycles, product=16'h004D.
  - Without the macro, both cases take 8 RUN cycles.

Source files
------------

// File: rtl/shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// shift_add_multiplier
//
// Sequential unsigned WIDTH x WIDTH shift-and-add multiplier. Each RUN cycle
// makes one adder pass, in the same shape as a hybrid_adder call:
//   a = ACC, b = (Q[0] ? M : 0), cin = 0.
// The 17-bit {cout, sum, Q} is then shifted right by one bit, so the carry
// lands in ACC[WIDTH-1] and is never lost.
//
// Handshake (start / busy / done):
//   - start is accepted in IDLE or DONE and ignored in RUN.
//   - a and b are captured on the accepting edge and may change afterwards.
//   - busy is high while the FSM is in RUN.
//   - done pulses for the single DONE cycle, when product becomes valid.
//   - product is held until the next result or a reset.
//   - Holding start high through DONE chains straight into the next RUN.
//
// Ports:
//   clk      in   system clock, rising edge
//   rst      in   synchronous active-high reset, overrides every other input
//   start    in   request a multiply
//   a        in   [WIDTH-1:0]   multiplicand
//   b        in   [WIDTH-1:0]   multiplier
//   product  out  [2*WIDTH-1:0] result
//   busy     out  high while running
//   done     out  one-cycle pulse when product updates
//
// Optional build macro: EARLY_TERM_EN
//   Defined:   RUN finishes as soon as the multiplier bits still to be consumed
//              are all zero. The product value is unchanged; only latency
//              shrinks.
//   Undefined: fixed WIDTH-iteration latency.
//
// WIDTH must be 8 to pair with hybrid_adder.
// -----------------------------------------------------------------------------
module shift_add_multiplier #(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] product,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q,   state_d;
    logic [WIDTH-1:0]     m_q,       m_d;
    logic [WIDTH-1:0]     acc_q,     acc_d;
    logic [WIDTH-1:0]     q_q,       q_d;
    logic [CW-1:0]        count_q,   count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;
    logic                 busy_q,    busy_d;
    logic                 done_q,    done_d;

    // Adder pass and the shifted {ACC,Q} it produces.
    logic [WIDTH-1:0]     addend;
    logic [WIDTH:0]       add_res;     // {cout, sum}
    logic [2*WIDTH-1:0]   next_pair;   // {cout, sum, Q[WIDTH-1:1]}

`ifdef EARLY_TERM_EN
    logic                 bits_left_zero;
    logic [CW:0]          early_shamt;
`endif

    always_comb begin
        addend    = q_q[0] ? m_q : '0;
        add_res   = {1'b0, acc_q} + {1'b0, addend};
        next_pair = {add_res, q_q[WIDTH-1:1]};

`ifdef EARLY_TERM_EN
        // Q[WIDTH-1-count:0] holds the multiplier bits not yet consumed.
        bits_left_zero = ((q_q & ({WIDTH{1'b1}} >> count_q)) == '0);
        // The missing right-shifts, all skipped adds of zero, are applied at once.
        early_shamt    = (CW + 1)'(WIDTH) - {1'b0, count_q};
`endif

        state_d   = state_q;
        m_d       = m_q;
        acc_d     = acc_q;
        q_d       = q_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            S_RUN: begin
`ifdef EARLY_TERM_EN
                if (bits_left_zero) begin
                    state_d   = S_DONE;
                    product_d = {acc_q, q_q} >> early_shamt;
                end else begin
`endif
                    {acc_d, q_d} = next_pair;
                    count_d      = count_q + 1'b1;
                    if (count_q == CW'(WIDTH - 1)) begin
                        state_d   = S_DONE;
                        product_d = next_pair;
                    end
`ifdef EARLY_TERM_EN
                end
`endif
            end
            default: begin  // S_IDLE, S_DONE: ready for a new request
                if (start) begin
                    state_d = S_RUN;
                    m_d     = a;
                    q_d     = b;
                    acc_d   = '0;
                    count_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
        endcase

        // Outputs are registered from the next state so they align with it.
        busy_d = (state_d == S_RUN);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            m_q       <= '0;
            acc_q     <= '0;
            q_q       <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            m_q       <= m_d;
            acc_q     <= acc_d;
            q_q       <= q_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign product = product_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// -----------------------------------------------------------------------------
// tb_shift_add_multiplier
//
// Directed bench for shift_add_multiplier.
//
// Reference model: an arithmetic model of the contract.
//   - An accepted request pushes a*b onto exp_q and arms a RUN-cycle countdown.
//   - The countdown length comes from the multiplier's bit-length, not from
//     the datapath.
//
// Checking:
//   - On every falling edge, product, busy and done are compared with the model.
//   - Directed scenarios add literal expectations for products, busy lengths
//     and reset behaviour.
// -----------------------------------------------------------------------------
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] product;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    shift_add_multiplier #(.WIDTH(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .busy    (busy),
        .done    (done)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Number of RUN cycles a multiply of multiplier value bv occupies.
    function automatic int run_cycles(input logic [7:0] bv);
`ifdef EARLY_TERM_EN
        int len;
        len = 0;
        for (int i = 0; i < 8; i++) if (bv[i]) len = i + 1;
        return (len + 1 > 8) ? 8 : len + 1;
`else
        return 8;
`endif
    endfunction

    // ---------------- reference model ----------------
    logic [15:0] exp_q[$];
    logic        m_valid = 1'b0;
    logic        m_busy;
    logic        m_done;
    logic [15:0] m_prod;
    int          m_left;

    always @(posedge clk) begin
        if (rst) begin
            m_valid <= 1'b1;
            m_busy  <= 1'b0;
            m_done  <= 1'b0;
            m_prod  <= 16'h0000;
            m_left  <= 0;
            exp_q.delete();
        end else if (m_valid) begin
            if (start && !m_busy) begin
                exp_q.push_back(16'(a) * 16'(b));
                m_left <= run_cycles(b);
                m_busy <= 1'b1;
                m_done <= 1'b0;
            end else if (m_busy) begin
                if (m_left == 1) begin
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                    m_prod <= exp_q.pop_front();
                end
                m_left <= m_left - 1;
            end else begin
                m_done <= 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_valid) begin
            chk("model_product", 32'(product), 32'(m_prod));
            chk("model_busy",    32'(busy),    32'(m_busy));
            chk("model_done",    32'(done),    32'(m_done));
        end
    end

    // ---------------- driver tasks ----------------
    // Called at a falling edge during RUN.
    // Returns at the falling edge inside the DONE cycle.
    task automatic wait_done(output int nbusy, output bit got);
        nbusy = 0;
        got   = 1'b0;
        for (int i = 0; i < 30; i++) begin
            if (done) begin
                got = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
    endtask

    task automatic run_mul(input logic [7:0] av, input logic [7:0] bv,
                           input logic [15:0] exp_p, input string name);
        int nb;
        bit got;
        start = 1'b1; a = av; b = bv;
        @(negedge clk);
        start = 1'b0; a = ~av; b = ~bv;   // operands must already be latched
        wait_done(nb, got);
        chk({name, "_done_seen"}, 32'(got), 32'd1);
        chk({name, "_product"}, 32'(product), 32'(exp_p));
        chk({name, "_busy_cycles"}, 32'(nb), 32'(run_cycles(bv)));
        @(negedge clk);
        chk({name, "_done_pulse_width"}, 32'(done), 32'd0);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : stim
        int nb;
        bit got;
        int dones;
        int pulse_at;

        rst = 1'b1; start = 1'b1; a = 8'd5; b = 8'd5;
        repeat (2) begin
            @(negedge clk);
            chk("reset_product", 32'(product), 32'h0);
            chk("reset_busy",    32'(busy),    32'd0);
            chk("reset_done",    32'(done),    32'd0);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("idle_after_reset_busy", 32'(busy), 32'd0);

        run_mul(8'd13,  8'd11,  16'h008F, "m13x11");
        run_mul(8'd255, 8'd255, 16'hFE01, "m255x255");
        run_mul(8'd77,  8'd0,   16'h0000, "m77x0");
        run_mul(8'd77,  8'd1,   16'h004D, "m77x1");
        run_mul(8'd1,   8'd128, 16'h0080, "m1x128");

        // A start pulse during RUN must be ignored.
`ifdef EARLY_TERM_EN
        pulse_at = 2;
`else
        pulse_at = 4;
`endif
        start = 1'b1; a = 8'd200; b = 8'd3;
        @(negedge clk);
        start = 1'b0; a = 8'd0; b = 8'd0;
        repeat (pulse_at - 1) @(negedge clk);
        start = 1'b1; a = 8'd1; b = 8'd1;
        @(negedge clk);
        start = 1'b0; a = 8'd0; b = 8'd0;
        wait_done(nb, got);
        chk("ignored_start_done_seen", 32'(got), 32'd1);
        chk("ignored_start_product", 32'(product), 32'h0258);

        // Back-to-back: start high in the DONE cycle.
        start = 1'b1; a = 8'd7; b = 8'd9;
        @(negedge clk);
        start = 1'b0; a = 8'd0; b = 8'd0;
        chk("b2b_busy", 32'(busy), 32'd1);
        chk("b2b_done_dropped", 32'(done), 32'd0);
        chk("b2b_product_held", 32'(product), 32'h0258);
        wait_done(nb, got);
        chk("b2b_done_seen", 32'(got), 32'd1);
        chk("b2b_product", 32'(product), 32'h003F);
        chk("b2b_busy_cycles", 32'(nb), 32'(run_cycles(8'd9)));
        @(negedge clk);

        // Reset in the middle of RUN discards the operation.
        start = 1'b1; a = 8'd100; b = 8'd100;
        @(negedge clk);
        start = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1; start = 1'b1;         // reset wins over start
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("midrst_busy",    32'(busy),    32'd0);
        chk("midrst_done",    32'(done),    32'd0);
        chk("midrst_product", 32'(product), 32'h0);
        dones = 0;
        repeat (12) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("midrst_no_done", 32'(dones), 32'd0);

        // start held high: re-issued once per DONE.
        start = 1'b1; a = 8'd3; b = 8'd5;
        dones = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) dones++;
        end
        start = 1'b0;
        if (busy) begin
            wait_done(nb, got);
            chk("held_start_final_done", 32'(got), 32'd1);
        end
        chk("held_start_product", 32'(product), 32'h000F);
        chk("held_start_reissued", 32'(dones >= 2), 32'd1);
        repeat (3) @(negedge clk);
        chk("held_start_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
